// File: rtl/bcd_conv_param.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional leading-zero blanking output is enabled by defining BCD_BLANK_EN.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | ready high, waiting for start
//   OP    | one correct-and-shift step per cycle, BIN_W cycles
//   DONE  | done_tick high, output registers load on exit
module bcd_conv_param #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done_tick,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
`ifdef BCD_BLANK_EN
    output logic [DIGITS-1:0]     blank,
`endif
    output logic [4:0]            sig_digits
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIN_W-1:0]     shreg_q;
    logic [4*DIGITS-1:0]  dig_q;
    logic                 ovf_acc_q;
    logic [4*DIGITS-1:0]  bcd_q;
    logic                 ovf_q;
    logic [4:0]           sig_q;
    logic                 done_q;
    logic                 ready_q;

    logic [4*DIGITS-1:0]  corr_d;
    logic [4*DIGITS-1:0]  chain_d;
    logic [4:0]           sig_d;

    // Per-digit correction is purely local; the only inter-digit path is the shift.
    always_comb begin
        corr_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_q[4*k +: 4] > 4'd4)
                corr_d[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
            else
                corr_d[4*k +: 4] = dig_q[4*k +: 4];
        end
        chain_d = {corr_d[4*DIGITS-2:0], shreg_q[BIN_W-1]};
    end

    always_comb begin
        sig_d = 5'd1;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_q[4*k +: 4] != 4'd0)
                sig_d = 5'(k + 1);
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_d;

    always_comb begin
        blank_d = '0;
        for (int k = 0; k < DIGITS; k++)
            blank_d[k] = (k >= int'(sig_d));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            blank_q <= ~DIGITS'(1);
        else if (state_q == DONE)
            blank_q <= blank_d;
    end

    assign blank = blank_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            dig_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            sig_q     <= 5'd1;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (start) begin
                        shreg_q   <= bin;
                        dig_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        cnt_q     <= CNT_W'(BIN_W);
                        state_q   <= OP;
                        ready_q   <= 1'b0;
                    end
                end
                OP: begin
                    dig_q     <= chain_d;
                    shreg_q   <= shreg_q << 1;
                    ovf_acc_q <= ovf_acc_q | corr_d[4*DIGITS-1];
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    bcd_q   <= dig_q;
                    ovf_q   <= ovf_acc_q;
                    sig_q   <= sig_d;
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign done_tick  = done_q;
    assign bcd        = bcd_q;
    assign ovf        = ovf_q;
    assign sig_digits = sig_q;

endmodule

// File: tb/tb_bcd_conv_param.sv
// Randomized bench for bcd_conv_param: a 7-digit and a 4-digit instance run in
// parallel and are compared against a decimal arithmetic reference model.
module tb_bcd_conv_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] bin = '0;

    logic        rdy_a, done_a, ovf_a;
    logic [27:0] bcd_a;
    logic [4:0]  sig_a;
    logic        rdy_b, done_b, ovf_b;
    logic [15:0] bcd_b;
    logic [4:0]  sig_b;
`ifdef BCD_BLANK_EN
    logic [6:0]  blank_a;
    logic [3:0]  blank_b;
`endif

    always #5 clk = ~clk;

    bcd_conv_param #(.BIN_W(20), .DIGITS(7)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .bin(bin),
        .ready(rdy_a), .done_tick(done_a), .bcd(bcd_a), .ovf(ovf_a),
`ifdef BCD_BLANK_EN
        .blank(blank_a),
`endif
        .sig_digits(sig_a)
    );

    bcd_conv_param #(.BIN_W(20), .DIGITS(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .bin(bin),
        .ready(rdy_b), .done_tick(done_b), .bcd(bcd_b), .ovf(ovf_b),
`ifdef BCD_BLANK_EN
        .blank(blank_b),
`endif
        .sig_digits(sig_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_sig(input longint unsigned v, input int d);
        int s = 1;
        for (int i = 0; i < d; i++) begin
            if (v % 10 != 0) s = i + 1;
            v = v / 10;
        end
        return 64'(s);
    endfunction

    function automatic logic [63:0] ref_ovf(input longint unsigned v, input int d);
        longint unsigned lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        return (v >= lim) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] ref_blank(input logic [63:0] s, input int d);
        logic [63:0] r = '0;
        for (int k = 0; k < d; k++) r[k] = (64'(k) >= s);
        return r;
    endfunction

    // Currently expected output-register contents of both instances.
    logic [63:0] e_bcd_a, e_sig_a, e_ovf_a, e_bcd_b, e_sig_b, e_ovf_b;

    task automatic exp_reset();
        e_bcd_a = 0; e_sig_a = 1; e_ovf_a = 0;
        e_bcd_b = 0; e_sig_b = 1; e_ovf_b = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".bcd_a"}, 64'(bcd_a), e_bcd_a);
        chk({tag, ".sig_a"}, 64'(sig_a), e_sig_a);
        chk({tag, ".ovf_a"}, 64'(ovf_a), e_ovf_a);
        chk({tag, ".bcd_b"}, 64'(bcd_b), e_bcd_b);
        chk({tag, ".sig_b"}, 64'(sig_b), e_sig_b);
        chk({tag, ".ovf_b"}, 64'(ovf_b), e_ovf_b);
`ifdef BCD_BLANK_EN
        chk({tag, ".blank_a"}, 64'(blank_a), ref_blank(e_sig_a, 7));
        chk({tag, ".blank_b"}, 64'(blank_b), ref_blank(e_sig_b, 4));
`endif
    endtask

    function automatic bit outputs_hold();
        return (64'(bcd_a) === e_bcd_a) && (64'(sig_a) === e_sig_a) && (64'(ovf_a) === e_ovf_a)
            && (64'(bcd_b) === e_bcd_b) && (64'(sig_b) === e_sig_b) && (64'(ovf_b) === e_ovf_b);
    endfunction

    // One conversion; optionally a second start is offered at cycle ign_at.
    task automatic convert(input logic [19:0] b, input int ign_at);
        int ndone = 0, ndone_b = 0, done_cyc = 0;
        bit hold_ok = 1'b1;
        @(negedge clk);
        bin = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ready_low_in_op", 64'(rdy_a), 64'd0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (done_a) begin ndone++; if (done_cyc == 0) done_cyc = cyc; end
            if (done_b) ndone_b++;
            if ((done_cyc == 0 || cyc == done_cyc) && !outputs_hold()) hold_ok = 1'b0;
            start = (cyc == ign_at);
            if (cyc == ign_at) bin = 20'd999;
            if (done_cyc != 0 && cyc == done_cyc + 1) break;
        end
        start = 1'b0;
        chk("done_cycle", 64'(done_cyc), 64'd21);
        chk("hold_prev", 64'(hold_ok), 64'd1);
        chk("ready_after", 64'(rdy_a), 64'd1);
        e_bcd_a = ref_bcd(64'(b), 7); e_sig_a = ref_sig(64'(b), 7); e_ovf_a = ref_ovf(64'(b), 7);
        e_bcd_b = ref_bcd(64'(b), 4); e_sig_b = ref_sig(64'(b), 4); e_ovf_b = ref_ovf(64'(b), 4);
        chk_outputs($sformatf("conv_%0d", b));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done_a) ndone++;
            if (done_b) ndone_b++;
        end
        chk("done_count_a", 64'(ndone), 64'd1);
        chk("done_count_b", 64'(ndone_b), 64'd1);
    endtask

    initial begin
        exp_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(rdy_a), 64'd1);
        chk("rst_done", 64'(done_a), 64'd0);
        chk_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);

        convert(20'd0, 0);
        convert(20'd1048575, 0);
        convert(20'd12345, 0);
        convert(20'd123456, 5);

        // Abort a conversion with reset at cycle 10
        @(negedge clk);
        bin = 20'd777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        exp_reset();
        chk("abort_ready", 64'(rdy_a), 64'd1);
        chk("abort_done", 64'(done_a), 64'd0);
        chk_outputs("abort");
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int nd = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done_a || done_b) nd++;
            end
            chk("abort_no_done", 64'(nd), 64'd0);
        end
        convert(20'd42, 0);
        convert(20'd305, 0);
        convert(20'd9999, 0);
        convert(20'd10000, 0);

        for (int n = 0; n < 20; n++)
            convert(20'($urandom_range(0, 1048575)), (n % 4 == 0) ? int'($urandom_range(2, 19)) : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
